conv_peak_detector: RTL and testbench

- Downstream consumer of the convolution core's result stream (data_res_out with its accompanying enable).
- Detects threshold-crossing peaks: records each peak's maximum value and sample index into an event FIFO.
- Software reads events and status over the same p_* register bus used by the convolution core.
- irq tells the CPU that events are pending.

---
 rtl/conv_peak_detector_pkg.sv | 28 ++
 rtl/conv_peak_detector_if.sv | 23 ++
 rtl/conv_peak_detector_sync_fifo.sv | 73 +++++++
 rtl/conv_peak_detector.sv | 260 ++++++++++++++++++++++++++
 tb/tb_conv_peak_detector.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_peak_detector_pkg.sv
// rtl/conv_peak_detector_pkg.sv - shared constants and state encodings for the peak detector
//
// Register word addresses, STATUS bit positions, detector and bus FSM encodings.
package conv_peak_detector_pkg;

  localparam logic [31:0] ADDR_THRESH = 32'h0;
  localparam logic [31:0] ADDR_CTRL   = 32'h1;
  localparam logic [31:0] ADDR_EVENT  = 32'h2;
  localparam logic [31:0] ADDR_STATUS = 32'h3;
  localparam logic [31:0] ADDR_HYST   = 32'h4;

  localparam int STATUS_COUNT_MSB = 8;
  localparam int STATUS_EMPTY_BIT = 9;
  localparam int STATUS_FULL_BIT  = 10;
  localparam int STATUS_OVF_BIT   = 11;

  typedef enum logic {
    DET_BELOW = 1'b0,
    DET_ABOVE = 1'b1
  } det_state_e;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_WRITE = 2'd1,
    BUS_READ  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/conv_peak_detector_if.sv
// rtl/conv_peak_detector_if.sv - p_* register bus shared with the convolution core
//
// Signals: p_sel, p_addr[31:0], p_wdata[31:0], p_ce, p_we (master -> slave);
//          p_rdy, p_rdata[31:0] (slave -> master).
interface conv_peak_detector_if;
  logic        p_sel;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_ce;
  logic        p_we;
  logic        p_rdy;
  logic [31:0] p_rdata;

  modport master (
    output p_sel, p_addr, p_wdata, p_ce, p_we,
    input  p_rdy, p_rdata
  );

  modport slave (
    input  p_sel, p_addr, p_wdata, p_ce, p_we,
    output p_rdy, p_rdata
  );
endinterface

// File: rtl/conv_peak_detector_sync_fifo.sv
// rtl/conv_peak_detector_sync_fifo.sv - show-ahead synchronous FIFO holding detected events
//
// Ports: clk, rst (sync, active-high), flush (drops all entries),
//        push/push_data, pop/pop_data (head word, valid while !empty),
//        count, full, empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign pop_data = mem[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/conv_peak_detector.sv
// rtl/conv_peak_detector.sv - threshold peak detector on the convolution result stream
//
// Ports: clk, rst (sync, active-high); data_in_enable/data_in (sample stream);
//        peak_valid/peak_value/peak_index (last pushed event); irq (events pending);
//        pbus (p_* register bus, slave modport).
// Registers: 0x0 THRESH, 0x1 CTRL {clear, det_en}, 0x2 EVENT (read pops),
//            0x3 STATUS {ovf, full, empty, count[8:0]}.
// Optional: CONV_PEAK_HYST_EN adds 0x4 HYST and exits an event below THRESH-HYST.
module conv_peak_detector
  import conv_peak_detector_pkg::*;
#(
  parameter int DATA_BITWIDTH    = 16,
  parameter int EVENT_FIFO_DEPTH = 16,
  parameter int INDEX_BITWIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_in_enable,
  input  logic [DATA_BITWIDTH-1:0]  data_in,
  output logic                      peak_valid,
  output logic [DATA_BITWIDTH-1:0]  peak_value,
  output logic [INDEX_BITWIDTH-1:0] peak_index,
  output logic                      irq,
  conv_peak_detector_if.slave       pbus
);

  localparam int CW = $clog2(EVENT_FIFO_DEPTH) + 1;

  bus_state_e                bus_state_q, bus_state_d;
  logic                      p_rdy_q, p_rdy_d;
  logic [31:0]               p_rdata_q, p_rdata_d;
  logic [DATA_BITWIDTH-1:0]  thresh_q, thresh_d;
  logic                      det_en_q, det_en_d;
  logic                      clear_q, clear_d;
  logic                      ovf_q, ovf_d;
  logic [INDEX_BITWIDTH-1:0] index_q, index_d;
  det_state_e                det_state_q, det_state_d;
  logic [DATA_BITWIDTH-1:0]  max_q, max_d;
  logic [INDEX_BITWIDTH-1:0] max_idx_q, max_idx_d;
  logic                      peak_valid_q, peak_valid_d;
  logic [DATA_BITWIDTH-1:0]  peak_value_q, peak_value_d;
  logic [INDEX_BITWIDTH-1:0] peak_index_q, peak_index_d;
  logic                      irq_q, irq_d;
`ifdef CONV_PEAK_HYST_EN
  logic [DATA_BITWIDTH-1:0]  hyst_q, hyst_d;
  logic [DATA_BITWIDTH-1:0]  exit_lvl;
`endif

  logic        wr_en, rd_en;
  logic [31:0] rd_word;
  logic [31:0] status_word;
  logic [15:0] max_val16;
  logic        event_pop, event_push;
  logic        sample_acc, at_or_above, exit_cond;
  logic [31:0] fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic        fifo_full, fifo_empty;
  logic        unused_wdata;

  assign unused_wdata = ^pbus.p_wdata[31:DATA_BITWIDTH];

  assign pbus.p_rdy   = p_rdy_q;
  assign pbus.p_rdata = p_rdata_q;
  assign peak_valid   = peak_valid_q;
  assign peak_value   = peak_value_q;
  assign peak_index   = peak_index_q;
  assign irq          = irq_q;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (EVENT_FIFO_DEPTH)
  ) u_event_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear_q),
    .push      (event_push),
    .push_data ({max_idx_q, max_val16}),
    .pop       (event_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Bus FSM: the access completes (write/pop/read capture) on the edge that raises p_rdy.
  always_comb begin
    bus_state_d = bus_state_q;
    p_rdy_d     = 1'b0;
    p_rdata_d   = '0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    case (bus_state_q)
      BUS_IDLE: begin
        if (pbus.p_sel) bus_state_d = pbus.p_we ? BUS_WRITE : BUS_READ;
      end
      BUS_WRITE: begin
        if (pbus.p_ce) begin
          p_rdy_d     = 1'b1;
          wr_en       = 1'b1;
          bus_state_d = BUS_IDLE;
        end
      end
      BUS_READ: begin
        if (pbus.p_ce) begin
          p_rdy_d     = 1'b1;
          rd_en       = 1'b1;
          p_rdata_d   = rd_word;
          bus_state_d = BUS_IDLE;
        end
      end
      default: bus_state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    status_word = '0;
    status_word[STATUS_COUNT_MSB:0] = 9'(fifo_count);
    status_word[STATUS_EMPTY_BIT]   = fifo_empty;
    status_word[STATUS_FULL_BIT]    = fifo_full;
    status_word[STATUS_OVF_BIT]     = ovf_q;

    rd_word = '0;
    case (pbus.p_addr)
      ADDR_THRESH: rd_word[DATA_BITWIDTH-1:0] = thresh_q;
      ADDR_CTRL:   rd_word[0] = det_en_q;
      ADDR_EVENT:  rd_word = fifo_empty ? '0 : fifo_rdata;
      ADDR_STATUS: rd_word = status_word;
`ifdef CONV_PEAK_HYST_EN
      ADDR_HYST:   rd_word[DATA_BITWIDTH-1:0] = hyst_q;
`endif
      default:     rd_word = '0;
    endcase
  end

  assign event_pop = rd_en && (pbus.p_addr == ADDR_EVENT) && !fifo_empty;

  // Register writes; clear is a one-cycle strobe acting on the following edge.
  always_comb begin
    thresh_d = thresh_q;
    det_en_d = det_en_q;
    clear_d  = 1'b0;
`ifdef CONV_PEAK_HYST_EN
    hyst_d   = hyst_q;
`endif
    if (wr_en) begin
      case (pbus.p_addr)
        ADDR_THRESH: thresh_d = pbus.p_wdata[DATA_BITWIDTH-1:0];
        ADDR_CTRL: begin
          det_en_d = pbus.p_wdata[0];
          clear_d  = pbus.p_wdata[1];
        end
`ifdef CONV_PEAK_HYST_EN
        ADDR_HYST:   hyst_d = pbus.p_wdata[DATA_BITWIDTH-1:0];
`endif
        default: ;
      endcase
    end
  end

  // Detector FSM.
  always_comb begin
    max_val16 = '0;
    max_val16[DATA_BITWIDTH-1:0] = max_q;

    sample_acc  = data_in_enable && det_en_q;
    at_or_above = (data_in >= thresh_q);
`ifdef CONV_PEAK_HYST_EN
    exit_lvl  = (thresh_q > hyst_q) ? (thresh_q - hyst_q) : '0;
    exit_cond = (data_in < exit_lvl);
`else
    exit_cond = !at_or_above;
`endif

    det_state_d  = det_state_q;
    max_d        = max_q;
    max_idx_d    = max_idx_q;
    index_d      = index_q;
    ovf_d        = ovf_q;
    event_push   = 1'b0;
    peak_valid_d = 1'b0;
    peak_value_d = peak_value_q;
    peak_index_d = peak_index_q;
    irq_d        = !fifo_empty;

    if (clear_q) begin
      det_state_d = DET_BELOW;
      index_d     = '0;
      ovf_d       = 1'b0;
    end else if (sample_acc) begin
      index_d = index_q + 1'b1;
      case (det_state_q)
        DET_BELOW: begin
          if (at_or_above) begin
            det_state_d = DET_ABOVE;
            max_d       = data_in;
            max_idx_d   = index_q;
          end
        end
        DET_ABOVE: begin
          if (exit_cond) begin
            det_state_d  = DET_BELOW;
            event_push   = 1'b1;
            peak_valid_d = 1'b1;
            peak_value_d = max_q;
            peak_index_d = max_idx_q;
            // A simultaneous pop frees a slot, so only an unrelieved full drops.
            if (fifo_full && !event_pop) ovf_d = 1'b1;
          end else if (at_or_above && (data_in > max_q)) begin
            max_d     = data_in;
            max_idx_d = index_q;
          end
        end
        default: det_state_d = DET_BELOW;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_state_q  <= BUS_IDLE;
      p_rdy_q      <= 1'b0;
      p_rdata_q    <= '0;
      thresh_q     <= '0;
      det_en_q     <= 1'b0;
      clear_q      <= 1'b0;
      ovf_q        <= 1'b0;
      index_q      <= '0;
      det_state_q  <= DET_BELOW;
      max_q        <= '0;
      max_idx_q    <= '0;
      peak_valid_q <= 1'b0;
      peak_value_q <= '0;
      peak_index_q <= '0;
      irq_q        <= 1'b0;
`ifdef CONV_PEAK_HYST_EN
      hyst_q       <= '0;
`endif
    end else begin
      bus_state_q  <= bus_state_d;
      p_rdy_q      <= p_rdy_d;
      p_rdata_q    <= p_rdata_d;
      thresh_q     <= thresh_d;
      det_en_q     <= det_en_d;
      clear_q      <= clear_d;
      ovf_q        <= ovf_d;
      index_q      <= index_d;
      det_state_q  <= det_state_d;
      max_q        <= max_d;
      max_idx_q    <= max_idx_d;
      peak_valid_q <= peak_valid_d;
      peak_value_q <= peak_value_d;
      peak_index_q <= peak_index_d;
      irq_q        <= irq_d;
`ifdef CONV_PEAK_HYST_EN
      hyst_q       <= hyst_d;
`endif
    end
  end

endmodule

// File: tb/tb_conv_peak_detector.sv
// tb/tb_conv_peak_detector.sv - directed self-checking bench for conv_peak_detector
module tb_conv_peak_detector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_in_enable = 1'b0;
  logic [15:0] data_in = '0;
  logic        peak_valid;
  logic [15:0] peak_value;
  logic [15:0] peak_index;
  logic        irq;
  int          total = 0;
  int          bad = 0;
  logic [31:0] rd;

  conv_peak_detector_if ifc ();

  conv_peak_detector #(
    .DATA_BITWIDTH    (16),
    .EVENT_FIFO_DEPTH (16),
    .INDEX_BITWIDTH   (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_enable (data_in_enable),
    .data_in        (data_in),
    .peak_valid     (peak_valid),
    .peak_value     (peak_value),
    .peak_index     (peak_index),
    .irq            (irq),
    .pbus           (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] d);
    int n;
    @(negedge clk);
    ifc.p_sel = 1'b1; ifc.p_we = we; ifc.p_addr = a; ifc.p_wdata = wd; ifc.p_ce = 1'b1;
    n = 0;
    @(negedge clk);
    while (ifc.p_rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bus_rdy", {31'd0, ifc.p_rdy}, 32'd1);
    d = ifc.p_rdata;
    ifc.p_sel = 1'b0; ifc.p_ce = 1'b0; ifc.p_we = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_xfer(1'b1, a, wd, dummy);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_xfer(1'b0, a, 32'd0, d);
  endtask

  task automatic feed(input int v);
    @(negedge clk);
    data_in = 16'(v);
    data_in_enable = 1'b1;
    @(negedge clk);
    data_in_enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.p_sel = 1'b0; ifc.p_addr = '0; ifc.p_wdata = '0; ifc.p_ce = 1'b0; ifc.p_we = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_peak_valid", {31'd0, peak_valid}, 32'd0);
    check("rst_peak_value", {16'd0, peak_value}, 32'd0);
    check("rst_peak_index", {16'd0, peak_index}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_p_rdy", {31'd0, ifc.p_rdy}, 32'd0);
    check("rst_p_rdata", ifc.p_rdata, 32'd0);
    bus_read(32'h0, rd); check("rst_thresh", rd, 32'd0);
    bus_read(32'h1, rd); check("rst_ctrl", rd, 32'd0);
    bus_read(32'h3, rd); check("rst_status", rd, 32'h0000_0200);
    @(negedge clk);
    check("rdy_one_cycle", {31'd0, ifc.p_rdy}, 32'd0);
    check("rdata_idle_zero", ifc.p_rdata, 32'd0);

    // Single peak
    bus_write(32'h0, 32'd100);
    bus_write(32'h1, 32'h1);
    bus_read(32'h0, rd); check("thresh_rb", rd, 32'd100);
    feed(50); feed(120); feed(180); feed(150);
    check("single_no_pv_early", {31'd0, peak_valid}, 32'd0);
    feed(90);
    check("single_pv", {31'd0, peak_valid}, 32'd1);
    check("single_value", {16'd0, peak_value}, 32'd180);
    check("single_index", {16'd0, peak_index}, 32'd2);
    @(negedge clk);
    check("single_pv_pulse", {31'd0, peak_valid}, 32'd0);
    check("single_value_hold", {16'd0, peak_value}, 32'd180);
    check("single_irq_on", {31'd0, irq}, 32'd1);
    bus_read(32'h3, rd); check("single_status", rd, 32'h0000_0001);
    bus_read(32'h2, rd); check("single_event", rd, 32'h0002_00B4);
    @(negedge clk);
    check("single_irq_off", {31'd0, irq}, 32'd0);
    bus_read(32'h2, rd); check("empty_event_read", rd, 32'd0);
    bus_read(32'h3, rd); check("empty_status", rd, 32'h0000_0200);

    // Tie keeps the earliest sample
    bus_write(32'h1, 32'h3);
    bus_write(32'h0, 32'd10);
    feed(20); feed(30); feed(30); feed(5);
    check("tie_pv", {31'd0, peak_valid}, 32'd1);
    check("tie_index", {16'd0, peak_index}, 32'd1);
    bus_read(32'h2, rd); check("tie_event", rd, 32'h0001_001E);

    // Clear mid-event discards the partial peak and restarts the index
    feed(50);
    bus_write(32'h1, 32'h3);
    bus_read(32'h3, rd); check("clear_status", rd, 32'h0000_0200);
    feed(40); feed(0);
    check("clear_pv", {31'd0, peak_valid}, 32'd1);
    check("clear_value", {16'd0, peak_value}, 32'd40);
    check("clear_index", {16'd0, peak_index}, 32'd0);
    bus_read(32'h2, rd); check("clear_event", rd, 32'h0000_0028);

    // det_en=0 freezes the index and ignores samples
    bus_write(32'h1, 32'h0);
    feed(200); feed(0);
    check("dis_no_pv", {31'd0, peak_valid}, 32'd0);
    bus_read(32'h3, rd); check("dis_status", rd, 32'h0000_0200);
    bus_write(32'h1, 32'h1);
    feed(60); feed(1);
    check("en_index", {16'd0, peak_index}, 32'd2);
    bus_read(32'h2, rd); check("en_event", rd, 32'h0002_003C);

    // Overflow: 17 peaks into a 16-deep FIFO
    bus_write(32'h1, 32'h3);
    for (int k = 0; k < 17; k++) begin
      feed(20 + k);
      feed(0);
    end
    check("ovf_pv", {31'd0, peak_valid}, 32'd1);
    check("ovf_last_index", {16'd0, peak_index}, 32'd32);
    check("ovf_last_value", {16'd0, peak_value}, 32'd36);
    bus_read(32'h3, rd); check("ovf_status", rd, 32'h0000_0C10);
    bus_read(32'h2, rd); check("ovf_first_event", rd, 32'h0000_0014);
    bus_read(32'h3, rd); check("ovf_sticky", rd, 32'h0000_080F);

    // Simultaneous push and pop while full
    bus_write(32'h1, 32'h3);
    for (int k = 0; k < 16; k++) begin
      feed(20 + k);
      feed(0);
    end
    bus_read(32'h3, rd); check("full_status", rd, 32'h0000_0410);
    feed(50);
    ifc.p_sel = 1'b1; ifc.p_we = 1'b0; ifc.p_addr = 32'h2; ifc.p_ce = 1'b1;
    @(negedge clk);
    data_in = 16'd0; data_in_enable = 1'b1;
    @(negedge clk);
    data_in_enable = 1'b0;
    check("simul_rdy", {31'd0, ifc.p_rdy}, 32'd1);
    check("simul_rdata", ifc.p_rdata, 32'h0000_0014);
    check("simul_pv", {31'd0, peak_valid}, 32'd1);
    check("simul_index", {16'd0, peak_index}, 32'd32);
    ifc.p_sel = 1'b0; ifc.p_ce = 1'b0;
    bus_read(32'h3, rd); check("simul_status", rd, 32'h0000_0410);
    bus_read(32'h2, rd); check("simul_next_event", rd, 32'h0002_0015);

    // Hysteresis (or plain threshold exit when the feature is absent)
    bus_write(32'h1, 32'h3);
    bus_write(32'h0, 32'd100);
    bus_write(32'h4, 32'd20);
    bus_read(32'h4, rd);
`ifdef CONV_PEAK_HYST_EN
    check("hyst_rb", rd, 32'd20);
`else
    check("hyst_rb", rd, 32'd0);
`endif
    feed(120); feed(95);
`ifdef CONV_PEAK_HYST_EN
    check("hyst_95_pv", {31'd0, peak_valid}, 32'd0);
`else
    check("hyst_95_pv", {31'd0, peak_valid}, 32'd1);
`endif
    feed(85); feed(79);
`ifdef CONV_PEAK_HYST_EN
    check("hyst_79_pv", {31'd0, peak_valid}, 32'd1);
`else
    check("hyst_79_pv", {31'd0, peak_valid}, 32'd0);
`endif
    check("hyst_value", {16'd0, peak_value}, 32'd120);
    check("hyst_index", {16'd0, peak_index}, 32'd0);
    bus_read(32'h3, rd); check("hyst_status", rd, 32'h0000_0001);
    bus_read(32'h2, rd); check("hyst_event", rd, 32'h0000_0078);

    // Unmapped addresses
    bus_write(32'h7, 32'hFFFF_FFFF);
    bus_read(32'h7, rd); check("unmapped_7", rd, 32'd0);
    bus_read(32'h5, rd); check("unmapped_5", rd, 32'd0);
    bus_read(32'h0, rd); check("thresh_kept", rd, 32'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
